updown_count_sequencer: RTL

//  Programmable controller that sequences a WIDTH-bit up/down counter between two bounds.

---
 rtl/updown_count_sequencer_if.sv | 33 +++
 rtl/updown_count_sequencer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/updown_count_sequencer_if.sv
// Purpose: bundles the control/config inputs and the status/count outputs of
//          updown_count_sequencer so the controller and its driver share one port.
// Ports (signals carried):
//   start, mode[1:0], lo, hi, loops, pause, abort  -> into the sequencer
//   count, dir, busy, done, err                    <- out of the sequencer
// Modports: master (drives config/control), slave (the sequencer itself).
interface updown_count_sequencer_if #(
  parameter int WIDTH   = 4,
  parameter int LOOPS_W = 4
);
  logic               start;
  logic [1:0]         mode;
  logic [WIDTH-1:0]   lo;
  logic [WIDTH-1:0]   hi;
  logic [LOOPS_W-1:0] loops;
  logic               pause;
  logic               abort;
  logic [WIDTH-1:0]   count;
  logic               dir;
  logic               busy;
  logic               done;
  logic               err;

  modport master (
    output start, mode, lo, hi, loops, pause, abort,
    input  count, dir, busy, done, err
  );

  modport slave (
    input  start, mode, lo, hi, loops, pause, abort,
    output count, dir, busy, done, err
  );
endinterface

// File: rtl/updown_count_sequencer.sv
// Purpose: sequences a WIDTH-bit up/down counter between inclusive bounds [lo,hi]
//          in up-wrap, down-wrap or bounce modes, for a programmed number of loops
//          (0 = free-run until abort), with a start/busy/done handshake.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      slave side of updown_count_sequencer_if (config/control in, status out)
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for start; count/dir hold their last value
// S_RUN  | stepping the counter once per unpaused edge; busy=1
module updown_count_sequencer #(
  parameter int WIDTH   = 4,
  parameter int LOOPS_W = 4
) (
  input logic                     clk,
  input logic                     reset_n,
  updown_count_sequencer_if.slave bus
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   count_q, count_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [1:0]         mode_q, mode_d;
  logic [LOOPS_W-1:0] loops_q, loops_d;
  logic               dir_q, dir_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic at_hi, at_lo, loop_end;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      mode_q  <= 2'b00;
      loops_q <= '0;
      dir_q   <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      mode_q  <= mode_d;
      loops_q <= loops_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    mode_d   = mode_q;
    loops_d  = loops_q;
    dir_d    = dir_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    loop_end = 1'b0;
    at_hi    = (count_q == hi_q);
    at_lo    = (count_q == lo_q);

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.lo > bus.hi) begin
            err_d = 1'b1;
          end else begin
            state_d = S_RUN;
            mode_d  = bus.mode;
            lo_d    = bus.lo;
            hi_d    = bus.hi;
            loops_d = bus.loops;
            // mode[0] selects the down-first variants (01, 11)
            if (bus.mode[0]) begin
              count_d = bus.hi;
              dir_d   = 1'b0;
            end else begin
              count_d = bus.lo;
              dir_d   = 1'b1;
            end
          end
        end
      end

      S_RUN: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (!bus.pause) begin
          // A degenerate range never moves and never turns: every edge ends a loop.
          if (lo_q == hi_q) begin
            loop_end = 1'b1;
          end else begin
            unique case (mode_q)
              2'b00: if (at_hi) loop_end = 1'b1; else count_d = count_q + 1'b1;
              2'b01: if (at_lo) loop_end = 1'b1; else count_d = count_q - 1'b1;
              2'b10: begin
                if (dir_q) begin
                  if (at_hi) begin
                    dir_d   = 1'b0;
                    count_d = count_q - 1'b1;
                  end else begin
                    count_d = count_q + 1'b1;
                  end
                end else if (at_lo) begin
                  loop_end = 1'b1;
                end else begin
                  count_d = count_q - 1'b1;
                end
              end
              2'b11: begin
                if (!dir_q) begin
                  if (at_lo) begin
                    dir_d   = 1'b1;
                    count_d = count_q + 1'b1;
                  end else begin
                    count_d = count_q - 1'b1;
                  end
                end else if (at_hi) begin
                  loop_end = 1'b1;
                end else begin
                  count_d = count_q + 1'b1;
                end
              end
            endcase
          end

          if (loop_end) begin
            if (loops_q == {{(LOOPS_W-1){1'b0}}, 1'b1}) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end else begin
              // loops_q==0 is free-run and is never decremented
              if (loops_q != '0) loops_d = loops_q - 1'b1;
              if (lo_q != hi_q) begin
                unique case (mode_q)
                  2'b00: count_d = lo_q;
                  2'b01: count_d = hi_q;
                  2'b10: begin
                    count_d = lo_q + 1'b1;
                    dir_d   = 1'b1;
                  end
                  2'b11: begin
                    count_d = hi_q - 1'b1;
                    dir_d   = 1'b0;
                  end
                endcase
              end
            end
          end
        end
      end
    endcase
  end

  assign bus.count = count_q;
  assign bus.dir   = dir_q;
  assign bus.busy  = (state_q == S_RUN);
  assign bus.done  = done_q;
  assign bus.err   = err_q;

endmodule
